// File: rtl/seg_pipe_adder.sv
// Segmented pipelined adder/subtractor: one SEG_W-bit segment per stage with the
// carry registered between stages, and a global-stall valid/ready handshake.
module seg_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG_W;
    localparam int MSB    = WIDTH - 1;

    logic             advance;
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];
    logic [SEG_W:0]   seg_add;
    logic             ovf_nxt;

    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];
    logic             ovf_p;

    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign advance  = !vld_p[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Stage k adds segment k; earlier stages' registers feed the next stage.
    always_comb begin
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        s_in[0] = '0;
        c_in[0] = sub ? ~cin : cin;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            s_in[k] = s_p[k-1];
            c_in[k] = c_p[k-1];
            v_in[k] = vld_p[k-1];
        end
        seg_add = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_add = {1'b0, a_in[k][k*SEG_W +: SEG_W]}
                    + {1'b0, b_in[k][k*SEG_W +: SEG_W]}
                    + (SEG_W+1)'(c_in[k]);
            s_nxt[k] = s_in[k];
            s_nxt[k][k*SEG_W +: SEG_W] = seg_add[SEG_W-1:0];
            c_nxt[k] = seg_add[SEG_W];
        end
        ovf_nxt = ovf_f(a_in[STAGES-1][MSB], b_in[STAGES-1][MSB], s_nxt[STAGES-1][MSB]);
    end

    // Pipeline registers: every stage shifts together or holds together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
            ovf_p <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= v_in[k];
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                s_p[k]   <= s_nxt[k];
                c_p[k]   <= c_nxt[k];
            end
            ovf_p <= ovf_nxt;
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign sum       = s_p[STAGES-1];
    assign cout      = c_p[STAGES-1];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Bench for seg_pipe_adder: three configurations (16/8, 32/8, 32/32) driven from
// shared stimulus, each scored against an integer-arithmetic reference model.
module tb_seg_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [31:0] a, b;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          strict = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum[31:0]} from plain integer arithmetic.
    function automatic logic [33:0] ref_model(input int w, input longint ua, input longint ub,
                                              input bit ci, input bit sb);
        longint m, sa, sbv, r, sr;
        bit co, ov;
        logic [31:0] s32;
        m   = longint'(1) << w;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (!sb) begin
            r  = ua + ub + longint'(ci);
            co = (r >= m);
            sr = sa + sbv + longint'(ci);
        end else begin
            r  = ua - ub - longint'(ci);
            co = (r >= 0);
            sr = sa - sbv - longint'(ci);
        end
        ov  = (sr >= m / 2) || (sr < -(m / 2));
        r   = ((r % m) + m) % m;
        s32 = r[31:0];
        return {ov, co, s32};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W  = (g == 0) ? 16 : 32;
        localparam int S  = (g == 2) ? 32 : 8;
        localparam int ST = W / S;
        logic         in_ready, out_valid, cout, ovf;
        logic [W-1:0] sum;
        logic [33:0]  exp_q [$];
        int           acc_q [$];
        bit           str_q [$];
        logic [33:0]  e;
        int           lat;
        bit           st;
        int           pops = 0;

        seg_pipe_adder #(.WIDTH(W), .SEG_W(S)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a[W-1:0]), .b(b[W-1:0]), .cin(cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready),
            .sum(sum), .cout(cout), .ovf(ovf)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                str_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("spurious_w%0d_s%0d", W, S), 1, 0);
                    end else begin
                        e   = exp_q.pop_front();
                        lat = cyc - acc_q.pop_front();
                        st  = str_q.pop_front();
                        chk($sformatf("sum_w%0d_s%0d", W, S), 64'(sum), 64'(e[W-1:0]));
                        chk($sformatf("cout_w%0d_s%0d", W, S), 64'(cout), 64'(e[32]));
                        chk($sformatf("ovf_w%0d_s%0d", W, S), 64'(ovf), 64'(e[33]));
                        if (st && strict) chk($sformatf("latency_w%0d_s%0d", W, S), 64'(lat), 64'(ST));
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_model(W, longint'(a[W-1:0]), longint'(b[W-1:0]), cin, sub));
                    acc_q.push_back(cyc);
                    str_q.push_back(strict);
                end
            end
        end
    end

    logic [15:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0000, 16'h0005};
    logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0002};
    bit          tc [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit          ts [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [15:0] es [7] = '{16'h0100, 16'h0000, 16'h8000, 16'h1235, 16'h7FFF, 16'hFFFF, 16'h0002};
    bit          ec [7] = '{0, 1, 0, 0, 1, 0, 1};
    bit          eo [7] = '{0, 0, 1, 0, 1, 0, 0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_beat();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int          k, p0, p1, p2;
        logic [15:0] hs;
        logic        hc, ho;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid0", 64'(g_dut[0].out_valid), 0);
        chk("rst_out_valid1", 64'(g_dut[1].out_valid), 0);
        chk("rst_out_valid2", 64'(g_dut[2].out_valid), 0);
        chk("rst_sum0", 64'(g_dut[0].sum), 0);
        chk("rst_cout_ovf0", 64'({g_dut[0].cout, g_dut[0].ovf}), 0);
        chk("rst_in_ready0", 64'(g_dut[0].in_ready), 1);
        rst_n  = 1'b1;
        strict = 1'b1;

        // Directed vectors on the 16/8 instance, one at a time.
        for (int i = 0; i < 7; i++) begin
            step();
            in_valid = 1'b1; a = {16'h0, ta[i]}; b = {16'h0, tb[i]}; cin = tc[i]; sub = ts[i];
            step();
            in_valid = 1'b0; rnd_beat();
            k = 0;
            while (k < 10) begin
                @(negedge clk);
                if (g_dut[0].out_valid) break;
                k++;
            end
            chk($sformatf("dir_latency_%0d", i), 64'(k), 1);
            chk($sformatf("dir_sum_%0d", i), 64'(g_dut[0].sum), 64'(es[i]));
            chk($sformatf("dir_cout_%0d", i), 64'(g_dut[0].cout), 64'(ec[i]));
            chk($sformatf("dir_ovf_%0d", i), 64'(g_dut[0].ovf), 64'(eo[i]));
        end
        repeat (6) step();

        // Eight back-to-back beats: each instance must retire exactly eight.
        p0 = g_dut[0].pops; p1 = g_dut[1].pops; p2 = g_dut[2].pops;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; rnd_beat();
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        chk("b2b_count_16_8", 64'(g_dut[0].pops - p0), 8);
        chk("b2b_count_32_8", 64'(g_dut[1].pops - p1), 8);
        chk("b2b_count_32_32", 64'(g_dut[2].pops - p2), 8);

        // Fill the pipe, then stall for five cycles holding the presented beat.
        strict = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; rnd_beat();
            step();
        end
        out_ready = 1'b0;
        @(negedge clk);
        hs = g_dut[0].sum; hc = g_dut[0].cout; ho = g_dut[0].ovf;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 64'(g_dut[0].in_ready), 0);
            chk("stall_out_valid", 64'(g_dut[0].out_valid), 1);
            chk("stall_sum", 64'(g_dut[0].sum), 64'(hs));
            chk("stall_cout_ovf", 64'({g_dut[0].cout, g_dut[0].ovf}), 64'({hc, ho}));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (8) step();

        // Random traffic with random back-pressure and an asynchronous reset mid-stream.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            rnd_beat();
            if (i == 150) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_out_valid0", 64'(g_dut[0].out_valid), 0);
                chk("async_rst_out_valid1", 64'(g_dut[1].out_valid), 0);
                chk("async_rst_out_valid2", 64'(g_dut[2].out_valid), 0);
                chk("async_rst_sum1", 64'(g_dut[1].sum), 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        chk("drain_16_8", 64'(g_dut[0].exp_q.size()), 0);
        chk("drain_32_8", 64'(g_dut[1].exp_q.size()), 0);
        chk("drain_32_32", 64'(g_dut[2].exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
